mux16_rr_arbiter: RTL

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

---
 rtl/mux16_arb_pkg.sv | 24 ++
 rtl/rr_pick16.sv | 29 ++
 rtl/mux16_rr_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mux16_arb_pkg.sv
// Shared constants, FSM state type and small index helpers for the
// 16-input round-robin mux arbiter.
package mux16_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        sel_to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << s;
    endfunction

    // Natural 4-bit overflow gives the 15 -> 0 wrap.
    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        sel_inc = s + 4'd1;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational wrap-around search: first set request at or above the
// pointer, wrapping 15 -> 0.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_found
);

    logic [SEL_W-1:0] w_cand;

    // Scan candidates ptr, ptr+1, ... and keep the first hit.
    always_comb begin
        o_idx   = i_ptr;
        o_found = 1'b0;
        w_cand  = i_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = i_ptr + SEL_W'(k);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end else begin
            end
        end
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving an external 16:1 mux select, waiting for the
// mux to settle, then presenting a registered sample until acknowledged.
// Optional macro MUX16_ARB_PRIO0_EN gives input 0 fixed priority.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 mux_out,
    output logic [SEL_W-1:0]     sel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 data_out,
    output logic                 data_valid,
    input  logic                 ack,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic               r_data_out;
    logic               w_data_out_nxt;
    logic               r_data_valid;
    logic               w_data_valid_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_busy;

    logic [SEL_W-1:0]   w_rr_idx;
    logic               w_rr_found;
    logic [SEL_W-1:0]   w_pick_idx;
    logic [SEL_W-1:0]   w_ptr_adv;

    rr_pick16 u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_idx   (w_rr_idx),
        .o_found (w_rr_found)
    );

`ifdef MUX16_ARB_PRIO0_EN
    // Input 0 pre-empts the rotation and never moves the pointer.
    assign w_pick_idx = req[0] ? 4'd0 : w_rr_idx;
    assign w_ptr_adv  = (r_sel == 4'd0) ? r_ptr : sel_inc(r_sel);
`else
    assign w_pick_idx = w_rr_idx;
    assign w_ptr_adv  = sel_inc(r_sel);
`endif

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_sel_nxt        = r_sel;
        w_gnt_nxt        = r_gnt;
        w_data_out_nxt   = r_data_out;
        w_data_valid_nxt = r_data_valid;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found) begin
                    w_sel_nxt   = w_pick_idx;
                    w_gnt_nxt   = sel_to_onehot(w_pick_idx);
                    w_cnt_nxt   = SETTLE_LD;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_gnt_nxt        = '0;
                    w_data_valid_nxt = 1'b0;
                end
            end
            ST_SETTLE: begin
                // Withdrawn request aborts before any sample is taken.
                if (!req[r_sel]) begin
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt <= 4'd1) begin
                    w_cnt_nxt        = '0;
                    w_data_out_nxt   = mux_out;
                    w_data_valid_nxt = 1'b1;
                    w_state_nxt      = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (ack) begin
                    w_data_valid_nxt = 1'b0;
                    w_gnt_nxt        = '0;
                    w_ptr_nxt        = w_ptr_adv;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_gnt_nxt        = '0;
                w_data_valid_nxt = 1'b0;
                w_cnt_nxt        = '0;
                w_state_nxt      = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_sel        <= '0;
            r_gnt        <= '0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_sel        <= w_sel_nxt;
            r_gnt        <= w_gnt_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_cnt        <= w_cnt_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign sel        = r_sel;
    assign gnt        = r_gnt;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign busy       = r_busy;

endmodule
